multiword_add_sequencer: RTL and testbench

MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

---
 rtl/multiword_add_sequencer.sv | 125 ++++++++++++
 tb/tb_multiword_add_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// Sequences a WORDS x 32-bit add through one external 32-bit adder, one chunk per cycle,
// from least significant to most significant. Define MWADD_SUB_EN to add a `sub` port (A-B).
module multiword_add_sequencer #(
  parameter int WORDS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [32*WORDS-1:0]   op_a,
  input  logic [32*WORDS-1:0]   op_b,
  input  logic                  cin,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [31:0]           adder_a,
  output logic [31:0]           adder_b,
  output logic                  adder_cin,
  input  logic [31:0]           adder_sum,
  input  logic                  adder_cout,
  input  logic                  adder_ovf,
  output logic [32*WORDS-1:0]   result,
  output logic                  cout,
  output logic                  overflow,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef MWADD_SUB_EN
  ,
  input  logic                  sub
`endif
);

  localparam int DATA_W = 32;
  localparam int IDX_W  = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [32*WORDS-1:0] a_r;
  logic [32*WORDS-1:0] b_r;
  logic                cin_r;
  logic                sub_r;
  logic                sub_in;
  logic                carry_r;
  logic [IDX_W-1:0]    idx;
  logic                last_chunk;
  logic                xfer;
  logic [DATA_W-1:0]   b_chunk;

`ifdef MWADD_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  assign xfer       = (state == IDLE) && in_valid;
  assign last_chunk = (idx == IDX_W'(WORDS - 1));
  assign b_chunk    = b_r[idx*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    adder_a   = '0;
    adder_b   = '0;
    adder_cin = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        adder_a = a_r[idx*DATA_W +: DATA_W];
        // Subtraction is A + ~B + 1; the forced 1 replaces cin on the first chunk.
        adder_b = sub_r ? ~b_chunk : b_chunk;
        if (idx == '0) adder_cin = sub_r ? 1'b1 : cin_r;
        else           adder_cin = carry_r;
        if (last_chunk) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and inter-chunk carry; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (xfer) begin
      a_r   <= op_a;
      b_r   <= op_b;
      cin_r <= cin;
      sub_r <= sub_in;
    end
    if (state == RUN) carry_r <= adder_cout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (xfer) begin
      idx <= '0;
    end else if (state == RUN) begin
      result[idx*DATA_W +: DATA_W] <= adder_sum;
      idx <= idx + IDX_W'(1);
      // Only the top chunk's carry and signed overflow describe the full-width add.
      if (last_chunk) begin
        cout     <= adder_cout;
        overflow <= adder_ovf;
      end
    end
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer (WORDS=2) with a behavioural 32-bit adder.
module tb_multiword_add_sequencer;

  localparam int WORDS = 2;
  localparam int W     = 32 * WORDS;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  op_a, op_b;
  logic          cin, in_valid, in_ready;
  logic [31:0]   adder_a, adder_b, adder_sum;
  logic          adder_cin, adder_cout, adder_ovf;
  logic [W-1:0]  result;
  logic          cout, overflow, out_valid, out_ready;
  logic          sub;

  typedef struct packed {
    logic [W-1:0] res;
    logic         co;
    logic         ov;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // Behavioural external adder
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {32'd0, adder_cin};
  assign adder_ovf = (adder_a[31] == adder_b[31]) && (adder_sum[31] != adder_a[31]);

  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b), .cin(cin),
    .in_valid(in_valid), .in_ready(in_ready),
    .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
    .adder_sum(adder_sum), .adder_cout(adder_cout), .adder_ovf(adder_ovf),
    .result(result), .cout(cout), .overflow(overflow),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef MWADD_SUB_EN
    , .sub(sub)
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic s);
    logic [W-1:0] bb;
    logic [W:0]   sum;
    exp_t e;
    bb    = s ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (s ? 1'b1 : c)};
    e.res = sum[W-1:0];
    e.co  = sum[W];
    e.ov  = (a[W-1] == bb[W-1]) && (sum[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one transfer, wait for the result, optionally stall, then compare and consume.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input int hold);
    int   n;
    exp_t e;
    logic [W-1:0] held_res;
    logic         held_co;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check("in_ready_before_xfer", in_ready, 1'b1);
    op_a = a; op_b = b; cin = c; sub = s; in_valid = 1'b1;
    sb_q.push_back(model(a, b, c, s));
    tick();
    in_valid = 1'b0;
    op_a = '1; op_b = '1;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("latency", n, WORDS);
    check("done_adder_a", adder_a, 32'd0);
    check("done_adder_cin", adder_cin, 1'b0);
    held_res = result;
    held_co  = cout;
    if (hold > 0) begin
      op_a = 64'h1234; op_b = 64'h5678; in_valid = 1'b1;
      for (int k = 0; k < hold; k++) begin
        tick();
        check("hold_out_valid", out_valid, 1'b1);
        check("hold_in_ready", in_ready, 1'b0);
        check("hold_result", result, held_res);
        check("hold_cout", cout, held_co);
      end
      in_valid = 1'b0;
    end
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      e = sb_q.pop_front();
      check("result", result, e.res);
      check("cout", cout, e.co);
      check("overflow", overflow, e.ov);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("consumed_out_valid", out_valid, 1'b0);
    check("consumed_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
    op_a = '0; op_b = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, '0);
    check("rst_cout", cout, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("idle_adder_b", adder_b, 32'd0);

    run_op(64'h00000000_FFFFFFFF, 64'h1, 1'b0, 1'b0, 0);
    run_op(64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b0, 0);
    run_op(64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0, 0);
    run_op(64'h01234567_89ABCDEF, 64'h0FEDCBA9_87654321, 1'b0, 1'b0, 5);
    for (int i = 0; i < 4; i++)
      run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'(i), 1'b0, 0);
`ifdef MWADD_SUB_EN
    run_op(64'd5, 64'd3, 1'b0, 1'b1, 0);
    run_op(64'd3, 64'd5, 1'b1, 1'b1, 0);
`endif

    // Reset during the first RUN cycle abandons the operation.
    op_a = 64'h00000000_FFFFFFFF; op_b = 64'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("run_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_result", result, '0);
    for (int k = 0; k < 4; k++) tick();
    check("abort_no_delivery", out_valid, 1'b0);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
